// File: rtl/xc20xx_clb_ctrl_mux.sv
// xc20xx_clb_ctrl_mux
// Clock-source, clock-polarity and reset-source selection for the XC20XX CLB
// storage element. The three 2-bit select fields live in a 6-bit config
// register. R loads the register from the parameters. While CFG_EN is high,
// the register shifts serially on rising K, LSB first.
// Optional feature macro: XC20XX_CFG_READBACK_EN adds CFG_DOUT = cfg[0], the
// serial output used for daisy-chaining the config register.
module xc20xx_clb_ctrl_mux #(
    parameter logic [1:0] CLKIN_S  = 2'h0,
    parameter logic [1:0] CLKPOL_S = 2'h0,
    parameter logic [1:0] RMUX_S   = 2'h2
) (
    input  logic K,
    input  logic R,
    input  logic C,
    input  logic D,
    input  logic G,
    input  logic CFG_EN,
    input  logic CFG_DIN,
    output logic CLK_SIG,
    output logic CLK_IN,
`ifdef XC20XX_CFG_READBACK_EN
    output logic CFG_DOUT,
`endif
    output logic R_IN
);

    localparam logic [5:0] CFG_DEFAULT = {RMUX_S, CLKPOL_S, CLKIN_S};

    logic [5:0] cfg;
    logic [1:0] clkin_sel;
    logic [1:0] pol_sel;
    logic [1:0] rmux_sel;

    assign clkin_sel = cfg[1:0];
    assign pol_sel   = cfg[3:2];
    assign rmux_sel  = cfg[5:4];

    // Config register. R restores the defaults without a clock. On a rising K
    // with CFG_EN high, CFG_DIN enters at bit 5 and bit 0 drops out.
    always_ff @(posedge K or posedge R) begin
        if (R)
            cfg <= CFG_DEFAULT;
        else if (CFG_EN)
            cfg <= {CFG_DIN, cfg[5:1]};
    end

    // Raw clock source. Reserved code 3 aliases to K, so there is no X.
    always_comb begin
        CLK_SIG = K;
        case (clkin_sel)
            2'd1:    CLK_SIG = C;
            2'd2:    CLK_SIG = G;
            default: CLK_SIG = K;
        endcase
    end

    // Polarity stage. Codes 2 and 3 tie the storage clock low.
    always_comb begin
        CLK_IN = 1'b0;
        case (pol_sel)
            2'd0:    CLK_IN = CLK_SIG;
            2'd1:    CLK_IN = ~CLK_SIG;
            default: CLK_IN = 1'b0;
        endcase
    end

    // Reset source. Codes 2 and 3 leave the storage reset inactive.
    always_comb begin
        R_IN = 1'b0;
        case (rmux_sel)
            2'd0:    R_IN = D;
            2'd1:    R_IN = G;
            default: R_IN = 1'b0;
        endcase
    end

`ifdef XC20XX_CFG_READBACK_EN
    // The bit that leaves the shift register on the next load edge.
    assign CFG_DOUT = cfg[0];
`endif

endmodule

// File: tb/tb_xc20xx_clb_ctrl_mux.sv
// Testbench for xc20xx_clb_ctrl_mux. It uses a scoreboard. The stimulus side
// computes each expected output from a behavioural model of the config word
// and the mux rules, then queues it. A monitor process samples the DUT and
// compares against the queue.
module tb_xc20xx_clb_ctrl_mux;

    typedef struct {
        string name;
        logic  clk_sig;
        logic  clk_in;
        logic  r_in;
        logic  dout;
    } exp_t;

    logic K, R, C, D, G, CFG_EN, CFG_DIN;
    logic CLK_SIG, CLK_IN, R_IN;
`ifdef XC20XX_CFG_READBACK_EN
    logic CFG_DOUT;
`endif

    xc20xx_clb_ctrl_mux dut (
        .K(K), .R(R), .C(C), .D(D), .G(G),
        .CFG_EN(CFG_EN), .CFG_DIN(CFG_DIN),
        .CLK_SIG(CLK_SIG), .CLK_IN(CLK_IN),
`ifdef XC20XX_CFG_READBACK_EN
        .CFG_DOUT(CFG_DOUT),
`endif
        .R_IN(R_IN)
    );

    // Free-running config clock.
    initial K = 1'b0;
    always #5 K = ~K;

    // The defaults are {rmux=2, pol=0, clkin=0}.
    localparam int DEF_CFG = 32;

    int   mcfg;
    exp_t sb[$];
    event chk_ev;
    int   checks = 0;
    int   errs   = 0;
    bit   done   = 0;

    // Reference model. Each field is pulled out of the integer config word
    // arithmetically, and the output is chosen by the rules for that field.
    function automatic exp_t model(input string nm);
        exp_t e;
        int clkin, pol, rm;
        logic src;
        clkin = mcfg % 4;
        pol   = (mcfg / 4) % 4;
        rm    = (mcfg / 16) % 4;
        if (clkin == 1)      src = C;
        else if (clkin == 2) src = G;
        else                 src = K;
        e.name    = nm;
        e.clk_sig = src;
        e.clk_in  = (pol == 0) ? src : (pol == 1) ? !src : 1'b0;
        e.r_in    = (rm == 0) ? D : (rm == 1) ? G : 1'b0;
        e.dout    = logic'(mcfg % 2);
        return e;
    endfunction

    task automatic check(input string nm);
        sb.push_back(model(nm));
        -> chk_ev;
        #2;
    endtask

    // Model shift: the new bit enters at weight 32 and the old bit 0 drops.
    task automatic shift_bit(input logic b);
        @(negedge K); #1;
        CFG_EN = 1'b1; CFG_DIN = b;
        @(posedge K); #1;
        if (!R) mcfg = mcfg / 2 + (b ? 32 : 0);
        CFG_EN = 1'b0;
    endtask

    task automatic load(input logic [5:0] v);
        for (int i = 0; i < 6; i++) shift_bit(v[i]);
    endtask

    task automatic at_low;
        @(negedge K); #1;
    endtask

    // Monitor: each time a check is issued, sample the DUT 1 ns later and
    // compare it with everything waiting in the queue.
    initial begin
        exp_t e;
        forever begin
            @(chk_ev);
            #1;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (CLK_SIG !== e.clk_sig || CLK_IN !== e.clk_in || R_IN !== e.r_in) begin
                    errs++;
                    $display("FAIL %s: got clk_sig=%b clk_in=%b r_in=%b, want %b %b %b",
                             e.name, CLK_SIG, CLK_IN, R_IN, e.clk_sig, e.clk_in, e.r_in);
                end
`ifdef XC20XX_CFG_READBACK_EN
                checks++;
                if (CFG_DOUT !== e.dout) begin
                    errs++;
                    $display("FAIL %s dout: got %b want %b", e.name, CFG_DOUT, e.dout);
                end
`endif
            end
        end
    end

    initial begin
        logic [5:0] v;
        R = 1'b1; C = 0; D = 0; G = 0; CFG_EN = 0; CFG_DIN = 0;
        mcfg = DEF_CFG;
        #3;
        check("reset_hold");
        @(negedge K); #1; R = 1'b0;

        // Defaults: the clock follows K at both levels, and R_IN stays 0 whatever D is.
        D = 1; check("def_klow");
        @(posedge K); #1; check("def_khigh");
        at_low; D = 0; check("def_d0");

        // Clock source C.
        load(6'b00_00_01);
        at_low; C = 1; check("src_c_1");
        C = 0; check("src_c_0");
        // Clock source G.
        load(6'b00_00_10);
        at_low; G = 1; check("src_g_1");

        // Negative polarity.
        load(6'b00_01_01);
        at_low; C = 1; check("pol_neg");
        // Polarity off.
        load(6'b00_10_01);
        at_low; C = 0; check("pol_none_c0");
        C = 1; check("pol_none_c1");

        // Reset sources.
        load(6'b00_00_00);
        at_low; D = 1; check("rmux_d");
        load(6'b01_00_00);
        at_low; G = 0; D = 1; check("rmux_g");
        load(6'b11_00_00);
        at_low; D = 1; G = 1; check("rmux_none");

        // Async reset in the middle of a load.
        shift_bit(1); shift_bit(0); shift_bit(1);
        check("partial_cfg");
        at_low; R = 1'b1; mcfg = DEF_CFG; check("reset_midload");
        CFG_EN = 1; CFG_DIN = 1;
        @(posedge K); #1; check("reset_beats_edge");
        at_low; CFG_EN = 0; R = 1'b0; check("reset_release");

        // Readback: a known pattern, with every intermediate state checked.
        for (int i = 0; i < 6; i++) begin
            v = 6'b101101;
            shift_bit(v[i]);
            check("readback_step");
        end

        // Random configurations with random data inputs.
        for (int it = 0; it < 16; it++) begin
            v = 6'($urandom_range(0, 63));
            for (int i = 0; i < 6; i++) begin
                shift_bit(v[i]);
                if (it % 4 == 0) check("rand_partial");
            end
            at_low;
            C = 1'($urandom); D = 1'($urandom); G = 1'($urandom);
            check("rand_klow");
            @(posedge K); #1;
            C = 1'($urandom); D = 1'($urandom); G = 1'($urandom);
            check("rand_khigh");
        end

        // Drain the queue, with a time bound.
        for (int t = 0; t < 20 && sb.size() > 0; t++) #1;
        if (sb.size() > 0) begin
            errs++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        done = 1;
        $finish;
    end

    // Absolute watchdog.
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
            $fatal(1);
        end
    end

endmodule
